mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//   Shares one mult32x32_fast instance between NUM_REQ requesters.
//   - Accepts operand pairs over per-requester valid/ready handshakes, with round-robin grant.
//   - Sequences the multiplier's start/busy protocol and holds operands stable while it runs.
//   - Returns each 64-bit product on one response channel, tagged with the requester id.
// PARAMETERS
//   NUM_REQ  4                   number of requesters (2..16)
//   ID_W     $clog2(NUM_REQ)     width of resp_id
// PORTS
//   clk          in   1            rising-edge clock
//   reset        in   1            asynchronous, active-low reset
//   req_valid    in   NUM_REQ      requester i has an operand pair pending
//   req_ready    out  NUM_REQ      one-hot accept pulse to the granted requester
//   req_a        in   NUM_REQ*32   packed operand a, slice i = requester i
//   req_b        in   NUM_REQ*32   packed operand b, slice i = requester i
//   resp_valid   out  1            product available
//   resp_ready   in   1            consumer accepts product
//   resp_id      out  ID_W         requester that issued the product
//   resp_product out  64           unsigned a*b
//   mul_start    out  1            to multiplier start; single-cycle pulse
//   mul_a        out  32           to multiplier a; registered, stable from start to result
//   mul_b        out  32           to multiplier b; registered, stable from start to result
//   mul_busy     in   1            from multiplier busy
//   mul_product  in   64           from multiplier product
// BEHAVIOUR
//   Reset (reset=0, async):
//   - All outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
//   - Integration drives the multiplier's reset from the same source, so both blocks reset together.
//   FSM states:
//   - IDLE: if |req_valid, grant g = first valid index after the rr pointer, wrapping modulo NUM_REQ.
//     Same cycle: req_ready[g]=1; capture req_a[g], req_b[g] into mul_a/mul_b and g into id_q;
//     rr pointer <= g; -> START. If no request is valid, stay in IDLE.
//   - START: mul_start=1 for exactly this cycle -> WAIT_HI.
//   - WAIT_HI: wait for mul_busy=1, then -> RUN.
//   - RUN: on mul_busy=0, resp_product <= mul_product and resp_id <= id_q -> RESP.
//     Latency is data-dependent; the block makes no assumption about its length.
//   - RESP: resp_valid=1, resp_product/resp_id held; on resp_ready=1 -> IDLE.
//   Handshake and timing rules:
//   - req_valid/req_a/req_b are held by the requester until req_ready; a request dropped before grant is ignored.
//   - At most one req_ready bit is high in any cycle, and only in IDLE.
//   - No new grant while START/WAIT_HI/RUN/RESP; a stalled resp_ready back-pressures all requesters.
//   - Minimum issue-to-issue time: IDLE+START+WAIT_HI+RUN(n)+RESP(1)+IDLE.
//   - mul_a/mul_b change only on a grant. The multiplier reads them every cycle, so they must not change mid-operation.
//   - WAIT_HI has no timeout; a multiplier that never asserts busy is an integration error. The bench flags it.
//   - reset asserted in any state: immediate return to IDLE; an in-flight result is discarded; no resp_valid.
// STRUCTURE
//   mult_arb_pkg:
//   - state_t enum {IDLE, START, WAIT_HI, RUN, RESP};
//   - localparams OP_W=32, PROD_W=64;
//   - function rr_pick(valid, ptr) returning index plus found flag.
//   Sub-module mult_rr_arbiter (NUM_REQ): combinational round-robin pick from req_valid and pointer.
//   The pointer register lives in the top block.
// TESTING
//   1. Single request: req 2, a=7, b=6.
//      -> req_ready[2] pulses once; mul_start pulses once; resp_product=42, resp_id=2.
//   2. All four valid continuously, resp_ready=1.
//      -> grant order 0,1,2,3,0; no requester granted twice before all others.
//   3. a=32'hFFFF_FFFF, b=32'hFFFF_FFFF.
//      -> resp_product=64'hFFFF_FFFE_0000_0001; mul_a/mul_b constant for the whole busy window.
//   4. Hold resp_ready=0 for 10 cycles with req 1 valid.
//      -> resp_valid and resp_product stable; req_ready stays 0 until after acceptance.
//   5. reset=0 while mul_busy=1, then release.
//      -> all outputs 0; no resp_valid for the aborted op; next grant goes to requester 0.
//   6. Reference-model scoreboard over 1000 random a/b/valid patterns.
//      -> every product correct; ids match the issuing requester; every request served exactly once.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared widths, FSM states and round-robin helper for the multiplier arbiter
package mult_arb_pkg;
  localparam int OP_W = 32;
  localparam int PROD_W = 64;
  localparam int MAX_REQ = 16;
  typedef enum logic [2:0] {IDLE, START, WAIT_HI, RUN, RESP} state_t;
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;
  // Scan downwards so the nearest valid index after ptr is the last one written.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [3:0] ptr, input int n);
    pick_t p;
    logic [3:0] j;
    p = '0;
    for (int k = n; k >= 1; k--) begin
      j = 4'((int'(ptr) + k) % n);
      if (valid[j]) begin
        p.found = 1'b1;
        p.idx = j;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: combinational round-robin pick of the first valid requester after ptr
module mult_rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    grant
);
  pick_t p;
  always_comb begin
    p = rr_pick(MAX_REQ'(valid), 4'(ptr), NUM_REQ);
    found = p.found;
    grant = ID_W'(p.idx);
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one multi-cycle multiplier between NUM_REQ requesters,
// returning each product tagged with the id of the requester that issued it.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [PROD_W-1:0]       resp_product,
  output logic                    mul_start,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic                    mul_busy,
  input  logic [PROD_W-1:0]       mul_product
);
  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] grant;
  logic            found;
  logic            take;

  mult_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid(req_valid),
    .ptr  (ptr),
    .found(found),
    .grant(grant)
  );

  // Gated by reset so no accept pulse leaks out while the block is held in reset.
  assign take = reset && state == IDLE && found;
  assign req_ready = take ? (NUM_REQ'(1) << grant) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= ID_W'(NUM_REQ - 1);
      id_q <= '0;
      mul_start <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_product <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          mul_a <= req_a[grant*OP_W +: OP_W];
          mul_b <= req_b[grant*OP_W +: OP_W];
          id_q <= grant;
          ptr <= grant;
          mul_start <= 1'b1;
          state <= START;
        end
        START: begin
          mul_start <= 1'b0;
          state <= WAIT_HI;
        end
        WAIT_HI: if (mul_busy) state <= RUN;
        RUN: if (!mul_busy) begin
          resp_product <= mul_product;
          resp_id <= id_q;
          resp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and random checks of the shared-multiplier arbiter
// against a transaction-level model plus a data-dependent-latency multiplier model.
module tb_mult_share_arbiter;
  localparam int N = 4;
  localparam int DEPTH = 1100;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [1:0]      resp_id;
  logic [63:0]     resp_product;
  logic            mul_start;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic            mul_busy;
  logic [63:0]     mul_product;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_product(resp_product),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy), .mul_product(mul_product)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Multiplier stand-in: busy rises after start, stays up 1..8 cycles depending on operands,
  // and shows junk on the product until it finishes.
  logic [3:0] mcnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_busy <= 1'b0;
      mcnt <= '0;
      mul_product <= '0;
    end else if (mul_start && !mul_busy) begin
      mul_busy <= 1'b1;
      mcnt <= 4'(mul_a[2:0] ^ mul_b[4:2]);
      mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (mul_busy) begin
      if (mcnt == 0) begin
        mul_busy <= 1'b0;
        mul_product <= {32'h0, mul_a} * {32'h0, mul_b};
      end else mcnt <= mcnt - 1;
    end
  end

  // Requester sources: per-requester op queues presented under valid/ready.
  logic [31:0] op_a [N][DEPTH];
  logic [31:0] op_b [N][DEPTH];
  int          rd [N] = '{default: 0};
  int          wr [N] = '{default: 0};
  logic [N-1:0] hs = '0;
  bit          rand_gate = 1'b0;
  bit          rand_ready = 1'b0;
  bit          hold_ready = 1'b1;

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] b);
    op_a[i][wr[i]] = a;
    op_b[i][wr[i]] = b;
    wr[i]++;
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        rd[i]++;
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && rd[i] != wr[i] && (!rand_gate || $urandom_range(0, 1) == 1)) begin
        req_valid[i] = 1'b1;
        req_a[i*32 +: 32] = op_a[i][rd[i]];
        req_b[i*32 +: 32] = op_b[i][rd[i]];
      end
    end
    resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : hold_ready;
  end

  // Transaction model: one op in flight, round-robin after the last grant,
  // response due the cycle after busy falls and held until accepted.
  int          last_g = N - 1;
  int          eg;
  bit          outst = 0, saw_busy = 0, rv_exp = 0, start_due = 0;
  logic [31:0] cur_a, cur_b;
  logic [1:0]  cur_id;
  int          grants [N] = '{default: 0};
  int          rdy_cnt [N] = '{default: 0};
  int          start_cnt = 0;
  int          resp_cnt = 0;
  int          glog [$];
  logic [1:0]  last_id;
  logic [63:0] last_prod;

  always @(negedge clk) begin
    hs = req_ready & req_valid;
    if (!reset) begin
      last_g = N - 1;
      outst = 0;
      saw_busy = 0;
      rv_exp = 0;
      start_due = 0;
    end else begin
      eg = -1;
      for (int k = N; k >= 1; k--) if (req_valid[(last_g + k) % N]) eg = (last_g + k) % N;
      chk("req_ready", 64'(req_ready), (!outst && eg >= 0) ? 64'(4'b1 << eg) : 64'h0);
      chk("mul_start", 64'(mul_start), 64'(start_due));
      chk("resp_valid", 64'(resp_valid), 64'(rv_exp));
      if (outst) begin
        chk("mul_a", 64'(mul_a), 64'(cur_a));
        chk("mul_b", 64'(mul_b), 64'(cur_b));
      end
      if (resp_valid) begin
        chk("resp_id", 64'(resp_id), 64'(cur_id));
        chk("resp_product", resp_product, {32'h0, cur_a} * {32'h0, cur_b});
      end
      for (int i = 0; i < N; i++) rdy_cnt[i] += int'(req_ready[i]);
      if (mul_start) start_cnt++;
      start_due = 0;
      if (outst && mul_busy) saw_busy = 1;
      else if (outst && saw_busy) begin
        saw_busy = 0;
        rv_exp = 1;
      end
      if (resp_valid && resp_ready) begin
        rv_exp = 0;
        outst = 0;
        resp_cnt++;
        last_id = resp_id;
        last_prod = resp_product;
      end else if (!outst && eg >= 0) begin
        outst = 1;
        last_g = eg;
        cur_a = req_a[eg*32 +: 32];
        cur_b = req_b[eg*32 +: 32];
        cur_id = 2'(eg);
        start_due = 1;
        grants[eg]++;
        glog.push_back(eg);
      end
    end
  end

  task automatic wait_resp(input int target, input int limit);
    int n = 0;
    while (resp_cnt < target && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    chk("resp_count", 64'(resp_cnt), 64'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base, g0, st, r2;
  int cnt6 [N];
  int gb [N];
  logic [31:0] ra, rb;
  initial begin
    #3 reset = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_mul_start", 64'(mul_start), 64'h0);
    chk("rst_mul_a", 64'(mul_a), 64'h0);
    chk("rst_resp_product", resp_product, 64'h0);
    // All four pending from reset release: order must start at 0 and rotate.
    for (int j = 0; j < 2; j++) for (int i = 0; i < N; i++) push(i, 32'(i * 10 + j + 1), 32'(100 + i));
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    wait_resp(8, 400);
    for (int k = 0; k < 8; k++) chk("t2_order", 64'(glog[k]), 64'(k % 4));
    // Single request from requester 2.
    base = resp_cnt; r2 = rdy_cnt[2]; st = start_cnt;
    push(2, 32'd7, 32'd6);
    wait_resp(base + 1, 200);
    chk("t1_product", last_prod, 64'd42);
    chk("t1_id", 64'(last_id), 64'd2);
    chk("t1_ready_pulses", 64'(rdy_cnt[2] - r2), 64'd1);
    chk("t1_start_pulses", 64'(start_cnt - st), 64'd1);
    // Largest operands.
    base = resp_cnt;
    push(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp(base + 1, 200);
    chk("t3_product", last_prod, 64'hFFFF_FFFE_0000_0001);
    // Back-pressure: response held, second requester stalled.
    base = resp_cnt;
    hold_ready = 1'b0;
    @(posedge clk); #2;
    push(1, 32'd123456, 32'd789);
    push(3, 32'd5, 32'd5);
    for (int n = 0; n < 100 && !resp_valid; n++) begin @(posedge clk); #2; end
    chk("t4_resp_seen", 64'(resp_valid), 64'h1);
    for (int n = 0; n < 10; n++) begin
      chk("t4_hold_valid", 64'(resp_valid), 64'h1);
      chk("t4_hold_product", resp_product, 64'd97406784);
      chk("t4_hold_ready", 64'(req_ready), 64'h0);
      @(posedge clk); #2;
    end
    hold_ready = 1'b1;
    wait_resp(base + 2, 200);
    chk("t4_last_id", 64'(last_id), 64'd3);
    chk("t4_last_product", last_prod, 64'd25);
    // Reset during a busy multiply discards the result.
    base = resp_cnt;
    push(3, 32'd1000, 32'd1000);
    for (int n = 0; n < 50 && !mul_busy; n++) begin @(posedge clk); #2; end
    chk("t5_busy_seen", 64'(mul_busy), 64'h1);
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("t5_resp_valid", 64'(resp_valid), 64'h0);
    chk("t5_mul_start", 64'(mul_start), 64'h0);
    chk("t5_mul_a", 64'(mul_a), 64'h0);
    chk("t5_mul_b", 64'(mul_b), 64'h0);
    chk("t5_resp_id", 64'(resp_id), 64'h0);
    chk("t5_resp_product", resp_product, 64'h0);
    g0 = glog.size();
    push(2, 32'd3, 32'd4);
    push(0, 32'd5, 32'd6);
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    wait_resp(base + 2, 200);
    chk("t5_first_grant", 64'(glog[g0]), 64'd0);
    chk("t5_last_id", 64'(last_id), 64'd2);
    chk("t5_last_product", last_prod, 64'd12);
    // Random traffic: every op served exactly once with a correct product.
    base = resp_cnt;
    for (int i = 0; i < N; i++) begin
      cnt6[i] = 0;
      gb[i] = grants[i];
    end
    rand_gate = 1'b1;
    rand_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      int i;
      i = $urandom_range(0, N - 1);
      ra = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom();
      rb = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom();
      push(i, ra, rb);
      cnt6[i]++;
    end
    wait_resp(base + 1000, 40000);
    for (int i = 0; i < N; i++) begin
      chk("t6_grants", 64'(grants[i] - gb[i]), 64'(cnt6[i]));
      chk("t6_drained", 64'(rd[i]), 64'(wr[i]));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
